// File: rtl/sega_mapper_pkg.sv
// Shared constants and types for the Sega-style cartridge bank mapper.
// Used by sega_mapper_regs and sega_rom_mapper.
package sega_mapper_pkg;

  localparam logic [15:0] ADDR_CTRL  = 16'hFFFC;
  localparam logic [15:0] ADDR_PAGE0 = 16'hFFFD;
  localparam logic [15:0] ADDR_PAGE1 = 16'hFFFE;
  localparam logic [15:0] ADDR_PAGE2 = 16'hFFFF;

  localparam logic [7:0] CTRL_RST  = 8'h00;
  localparam logic [7:0] PAGE0_RST = 8'h00;
  localparam logic [7:0] PAGE1_RST = 8'h01;
  localparam logic [7:0] PAGE2_RST = 8'h02;

  localparam logic [15:0] SLOT1_BASE  = 16'h4000;
  localparam logic [15:0] SLOT2_BASE  = 16'h8000;
  localparam logic [15:0] SYSRAM_BASE = 16'hC000;

  localparam logic [15:0] FIXED_SIZE = 16'h0400;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_PAGE0 = 2'd1,
    REG_PAGE1 = 2'd2,
    REG_PAGE2 = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [7:0] ctrl;
    logic [7:0] page0;
    logic [7:0] page1;
    logic [7:0] page2;
  } map_regs_t;

  function automatic logic is_reg_addr(input logic [15:0] a);
    return a[15:2] == ADDR_CTRL[15:2];
  endfunction

endpackage

// File: rtl/sega_mapper_regs.sv
// Paging register file (FFFC-FFFF) with Z80 write decode.
// Writes land on the sampling clock edge; reset is asynchronous.
module sega_mapper_regs
  import sega_mapper_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  di,
  output map_regs_t   regs
);

  map_regs_t regs_q;
  map_regs_t regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr && is_reg_addr(addr)) begin
      unique case (reg_sel_e'(addr[1:0]))
        REG_CTRL:  regs_d.ctrl  = di;
        REG_PAGE0: regs_d.page0 = di;
        REG_PAGE1: regs_d.page1 = di;
        REG_PAGE2: regs_d.page2 = di;
        default:   regs_d = regs_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q.ctrl  <= CTRL_RST;
      regs_q.page0 <= PAGE0_RST;
      regs_q.page1 <= PAGE1_RST;
      regs_q.page2 <= PAGE2_RST;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs = regs_q;

endmodule

// File: rtl/sega_rom_mapper.sv
// Sega cartridge mapper: Z80 16-bit address -> 22-bit ROM address.
// Define SEGA_MAPPER_CART_RAM_EN to route slot 2 to on-cart RAM.
module sega_rom_mapper
  import sega_mapper_pkg::*;
#(
  parameter logic [7:0] BANK_MASK = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  di,
`ifdef SEGA_MAPPER_CART_RAM_EN
  output logic        cart_ram_sel,
  output logic [14:0] cart_ram_addr,
`endif
  output logic [21:0] flash_addr
);

  map_regs_t regs;

  sega_mapper_regs u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .addr  (addr),
    .di    (di),
    .regs  (regs)
  );

  logic fixed_win;
  logic in_slot0;
  logic in_slot1;
  logic in_slot2;
  logic in_sysram;
  logic [7:0] bank;

  assign fixed_win = addr < FIXED_SIZE;
  assign in_sysram = addr >= SYSRAM_BASE;
  assign in_slot2  = !in_sysram && (addr >= SLOT2_BASE);
  assign in_slot1  = (addr >= SLOT1_BASE) && (addr < SLOT2_BASE);
  assign in_slot0  = !fixed_win && (addr < SLOT1_BASE);

  // Fixed 1 KB window keeps the Z80 vectors reachable whatever page0 holds.
  always_comb begin
    bank = 8'h00;
    unique case (1'b1)
      fixed_win: bank = 8'h00;
      in_slot0:  bank = regs.page0 & BANK_MASK;
      in_slot1:  bank = regs.page1 & BANK_MASK;
      in_slot2:  bank = regs.page2 & BANK_MASK;
      in_sysram: bank = 8'h00;
      default:   bank = 8'h00;
    endcase
  end

  assign flash_addr = {bank, addr[13:0]};

`ifdef SEGA_MAPPER_CART_RAM_EN
  assign cart_ram_sel  = regs.ctrl[3] & in_slot2;
  assign cart_ram_addr = {regs.ctrl[2], addr[13:0]};

  logic unused_ctrl;
  assign unused_ctrl = ^{regs.ctrl[7:4], regs.ctrl[1:0]};
`else
  logic unused_ctrl;
  assign unused_ctrl = ^regs.ctrl;
`endif

endmodule

// File: tb/tb_sega_rom_mapper.sv
// Scoreboard bench for sega_rom_mapper: full-mask and 4-bit-mask
// instances share stimulus and are compared against a behavioural model.
module tb_sega_rom_mapper;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  di;
  logic [21:0] fa;
  logic [21:0] fa_m;
`ifdef SEGA_MAPPER_CART_RAM_EN
  logic        sel;
  logic [14:0] raddr;
  logic        sel_m;
  logic [14:0] raddr_m;
`endif

  sega_rom_mapper #(.BANK_MASK(8'hFF)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr            (wr),
    .addr          (addr),
    .di            (di),
`ifdef SEGA_MAPPER_CART_RAM_EN
    .cart_ram_sel  (sel),
    .cart_ram_addr (raddr),
`endif
    .flash_addr    (fa)
  );

  sega_rom_mapper #(.BANK_MASK(8'h0F)) u_dut_m (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr            (wr),
    .addr          (addr),
    .di            (di),
`ifdef SEGA_MAPPER_CART_RAM_EN
    .cart_ram_sel  (sel_m),
    .cart_ram_addr (raddr_m),
`endif
    .flash_addr    (fa_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [21:0] f;
    logic [21:0] fm;
    logic        sel;
    logic [14:0] ra;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: control byte plus one page number per 16 KB slot.
  logic [7:0] m_ctrl;
  logic [7:0] m_page [3];

  function automatic void model_reset();
    m_ctrl    = 8'h00;
    m_page[0] = 8'h00;
    m_page[1] = 8'h01;
    m_page[2] = 8'h02;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'hFFFC) m_ctrl = d;
    else if (a >= 16'hFFFD) m_page[int'(a) - 'hFFFD] = d;
  endfunction

  function automatic logic [21:0] model_flash(input logic [15:0] a, input logic [7:0] mask);
    int slot;
    int off;
    int bnk;
    slot = int'(a) / 16384;
    off  = int'(a) % 16384;
    if (int'(a) < 1024 || slot == 3) bnk = 0;
    else bnk = int'(m_page[slot] & mask);
    return 22'(bnk * 16384 + off);
  endfunction

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s addr=%h actual=%h required=%h", nm, a, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".flash"}, e.a, 32'(fa), 32'(e.f));
      chk({e.name, ".flash_m"}, e.a, 32'(fa_m), 32'(e.fm));
`ifdef SEGA_MAPPER_CART_RAM_EN
      chk({e.name, ".ram_sel"}, e.a, 32'(sel), 32'(e.sel));
      chk({e.name, ".ram_addr"}, e.a, 32'(raddr), 32'(e.ra));
      chk({e.name, ".ram_sel_m"}, e.a, 32'(sel_m), 32'(e.sel));
      chk({e.name, ".ram_addr_m"}, e.a, 32'(raddr_m), 32'(e.ra));
`endif
    end
  end

  task automatic do_read(input string nm, input logic [15:0] a);
    exp_t e;
    wr   = 1'b0;
    addr = a;
    e.name = nm;
    e.a    = a;
    e.f    = model_flash(a, 8'hFF);
    e.fm   = model_flash(a, 8'h0F);
    e.sel  = m_ctrl[3] && (a >= 16'h8000) && (a < 16'hC000);
    e.ra   = {m_ctrl[2], a[13:0]};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int n);
    wr   = 1'b1;
    addr = a;
    di   = d;
    repeat (n) @(posedge clk);
    #1;
    wr = 1'b0;
    model_write(a, d);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    do_read("rst_pulse", 16'(32'h4000 + $urandom_range(0, 32'h3FFF)));
    rst_n = 1'b1;
  endtask

  logic [15:0] edges [8];

  initial begin
    edges[0] = 16'h03FF; edges[1] = 16'h0400;
    edges[2] = 16'h3FFF; edges[3] = 16'h4000;
    edges[4] = 16'h7FFF; edges[5] = 16'h8000;
    edges[6] = 16'hBFFF; edges[7] = 16'hC000;
    rst_n = 1'b0;
    wr    = 1'b0;
    addr  = 16'h0000;
    di    = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_read("rst_s0", 16'h0005);
    do_read("rst_s1", 16'h4005);
    do_read("rst_s2", 16'h8005);
    do_write(16'hFFFF, 8'h05, 1);
    do_read("p2_new", 16'h8123);
    do_read("p1_keep", 16'h4123);
    do_write(16'hFFFD, 8'h03, 1);
    do_read("fixed", 16'h0200);
    do_read("fixed_edge", 16'h03FF);
    do_read("p0_new", 16'h0400);
    do_write(16'hFFFE, 8'h13, 1);
    do_read("mirror", 16'h4000);
    do_write(16'h1234, 8'h7F, 1);
    do_read("ign_wr", 16'h4000);
    do_write(16'hFFFC, 8'h0C, 1);
    do_read("ram_s2", 16'h8010);
    do_read("ram_s1", 16'h4010);
    do_read("sysram", 16'hFFFE);
    do_write(16'hFFFE, 8'h27, 3);
    do_read("held_wr", 16'h7ABC);

    rst_n = 1'b0;
    model_reset();
    do_read("arst_s0", 16'h0000);
    do_read("arst_s1", 16'h4000);
    do_read("arst_s2", 16'h8000);
    do_read("arst_ram", 16'h8010);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 5)
        do_write(16'(32'hFFFC + $urandom_range(0, 3)), 8'($urandom), 1);
      else if (r == 5)
        do_write(16'($urandom_range(0, 32'hFFFB)), 8'($urandom), 1);
      else if (r == 6)
        pulse_reset();
      else if (r < 10)
        do_read("rnd_edge", edges[$urandom_range(0, 7)]);
      else
        do_read("rnd", 16'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 16'h0000, 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
